ctrl_pipe: RTL and testbench

CTRL_PIPE -- requirements
Module: ctrl_pipe

---
 rtl/ctrl_pkg.sv | 63 ++++++
 rtl/branch_cond.sv | 30 +++
 rtl/ctrl_pipe.sv | 98 +++++++++
 tb/tb_ctrl_pipe.sv | 270 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/ctrl_pkg.sv
// Shared control encodings and pipeline bundles for the
// RV32I control path, decoder and datapath.
package ctrl_pkg;

    localparam logic [1:0] RES_ALU = 2'b00;
    localparam logic [1:0] RES_MEM = 2'b01;
    localparam logic [1:0] RES_PC4 = 2'b10;

    localparam logic [1:0] FWD_RF  = 2'b00;
    localparam logic [1:0] FWD_WB  = 2'b01;
    localparam logic [1:0] FWD_MEM = 2'b10;

    localparam logic [2:0] F3_BEQ  = 3'b000;
    localparam logic [2:0] F3_BNE  = 3'b001;
    localparam logic [2:0] F3_BLT  = 3'b100;
    localparam logic [2:0] F3_BGE  = 3'b101;
    localparam logic [2:0] F3_BLTU = 3'b110;
    localparam logic [2:0] F3_BGEU = 3'b111;

    typedef struct packed {
        logic       branch;
        logic       jump;
        logic       memwrite;
        logic       alusrc;
        logic       regwrite;
        logic [1:0] resultsrc;
        logic [1:0] aluop;
        logic [2:0] funct3;
        logic [4:0] rs1;
        logic [4:0] rs2;
        logic [4:0] rd;
    } id_ex_t;

    typedef struct packed {
        logic       memwrite;
        logic       regwrite;
        logic [1:0] resultsrc;
        logic [4:0] rd;
    } ex_mem_t;

    typedef struct packed {
        logic       regwrite;
        logic [1:0] resultsrc;
        logic [4:0] rd;
    } mem_wb_t;

    // x0 never sources a forward; MEM wins over WB
    function automatic logic [1:0] fwd_sel(
        input logic [4:0] rs,
        input logic       mwe,
        input logic [4:0] mrd,
        input logic       wwe,
        input logic [4:0] wrd
    );
        if (mwe && mrd != 5'd0 && mrd == rs)
            return FWD_MEM;
        else if (wwe && wrd != 5'd0 && wrd == rs)
            return FWD_WB;
        else
            return FWD_RF;
    endfunction

endpackage

// File: rtl/branch_cond.sv
// EX-stage branch condition evaluation from funct3
// and the ALU compare flags {ltu, lt, zero}.
module branch_cond
    import ctrl_pkg::*;
(
    input  logic [2:0] funct3,
    input  logic [2:0] flags,
    output logic       taken
);

    logic ltu, lt, zero;

    assign ltu  = flags[2];
    assign lt   = flags[1];
    assign zero = flags[0];

    always_comb begin
        taken = 1'b0;
        unique case (1'b1)
            (funct3 == F3_BEQ):  taken = zero;
            (funct3 == F3_BNE):  taken = !zero;
            (funct3 == F3_BLT):  taken = lt;
            (funct3 == F3_BGE):  taken = !lt;
            (funct3 == F3_BLTU): taken = ltu;
            (funct3 == F3_BGEU): taken = !ltu;
            default:             taken = 1'b0;
        endcase
    end

endmodule

// File: rtl/ctrl_pipe.sv
// Pipelined control path: E/M/W control registers,
// hazard detection and forwarding selects.
module ctrl_pipe
    import ctrl_pkg::*;
(
    input  logic       clk,
    input  logic       reset,
    input  logic       BranchD,
    input  logic       JumpD,
    input  logic       MemWriteD,
    input  logic       ALUSrcD,
    input  logic       RegWriteD,
    input  logic [1:0] ResultSrcD,
    input  logic [1:0] ALUOpD,
    input  logic [2:0] funct3D,
    input  logic [4:0] Rs1D,
    input  logic [4:0] Rs2D,
    input  logic [4:0] RdD,
    input  logic [2:0] FlagsE,
    output logic       StallFD,
    output logic       FlushD,
    output logic       PCSrcE,
    output logic [1:0] ForwardAE,
    output logic [1:0] ForwardBE,
    output logic       ALUSrcE,
    output logic [1:0] ALUOpE,
    output logic       MemWriteM,
    output logic       RegWriteW,
    output logic [1:0] ResultSrcW,
    output logic [4:0] RdW
);

    id_ex_t  d, e;
    ex_mem_t m;
    mem_wb_t w;
    logic    taken, loadstall, flushe;

    assign d = '{
        branch:    BranchD,
        jump:      JumpD,
        memwrite:  MemWriteD,
        alusrc:    ALUSrcD,
        regwrite:  RegWriteD,
        resultsrc: ResultSrcD,
        aluop:     ALUOpD,
        funct3:    funct3D,
        rs1:       Rs1D,
        rs2:       Rs2D,
        rd:        RdD
    };

    branch_cond u_bc (
        .funct3 (e.funct3),
        .flags  (FlagsE),
        .taken  (taken)
    );

    assign loadstall = (e.resultsrc == RES_MEM)
                     && (e.rd != 5'd0)
                     && (e.rd == Rs1D || e.rd == Rs2D);

    assign PCSrcE  = e.jump | (e.branch & taken);
    // a redirect kills D, so its hazard is moot
    assign StallFD = loadstall & !PCSrcE;
    assign FlushD  = PCSrcE;
    assign flushe  = loadstall | PCSrcE;

    always_ff @(posedge clk) begin
        if (reset || flushe)
            e <= '0;
        else
            e <= d;
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            m <= '0;
            w <= '0;
        end else begin
            m <= '{e.memwrite, e.regwrite,
                   e.resultsrc, e.rd};
            w <= '{m.regwrite, m.resultsrc, m.rd};
        end
    end

    assign ForwardAE = fwd_sel(e.rs1, m.regwrite,
                               m.rd, w.regwrite, w.rd);
    assign ForwardBE = fwd_sel(e.rs2, m.regwrite,
                               m.rd, w.regwrite, w.rd);

    assign ALUSrcE    = e.alusrc;
    assign ALUOpE     = e.aluop;
    assign MemWriteM  = m.memwrite;
    assign RegWriteW  = w.regwrite;
    assign ResultSrcW = w.resultsrc;
    assign RdW        = w.rd;

endmodule

// File: tb/tb_ctrl_pipe.sv
// Directed and random checks of ctrl_pipe against an
// instruction-history reference model.
module tb_ctrl_pipe;

    logic       clk = 1'b0;
    logic       reset;
    logic       BranchD, JumpD, MemWriteD, ALUSrcD;
    logic       RegWriteD;
    logic [1:0] ResultSrcD, ALUOpD;
    logic [2:0] funct3D;
    logic [4:0] Rs1D, Rs2D, RdD;
    logic [2:0] FlagsE;
    logic       StallFD, FlushD, PCSrcE;
    logic [1:0] ForwardAE, ForwardBE;
    logic       ALUSrcE;
    logic [1:0] ALUOpE;
    logic       MemWriteM, RegWriteW;
    logic [1:0] ResultSrcW;
    logic [4:0] RdW;

    int n_assert = 0;
    int n_fail   = 0;
    bit armed    = 0;

    typedef struct packed {
        logic       br, jp, mw, as, rw;
        logic [1:0] rs, op;
        logic [2:0] f3;
        logic [4:0] a, b, rd;
    } instr_t;

    // q[$] is in EX, q[$-1] in MEM, q[$-2] in WB
    instr_t q[$];

    always #5 clk = ~clk;

    ctrl_pipe dut (
        .clk        (clk),
        .reset      (reset),
        .BranchD    (BranchD),
        .JumpD      (JumpD),
        .MemWriteD  (MemWriteD),
        .ALUSrcD    (ALUSrcD),
        .RegWriteD  (RegWriteD),
        .ResultSrcD (ResultSrcD),
        .ALUOpD     (ALUOpD),
        .funct3D    (funct3D),
        .Rs1D       (Rs1D),
        .Rs2D       (Rs2D),
        .RdD        (RdD),
        .FlagsE     (FlagsE),
        .StallFD    (StallFD),
        .FlushD     (FlushD),
        .PCSrcE     (PCSrcE),
        .ForwardAE  (ForwardAE),
        .ForwardBE  (ForwardBE),
        .ALUSrcE    (ALUSrcE),
        .ALUOpE     (ALUOpE),
        .MemWriteM  (MemWriteM),
        .RegWriteW  (RegWriteW),
        .ResultSrcW (ResultSrcW),
        .RdW        (RdW)
    );

    task automatic chk(input string tag,
                       input logic [7:0] obs,
                       input logic [7:0] exp);
        n_assert++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s observed=%0h expected=%0h",
                   tag, obs, exp);
        end
    endtask

    function automatic logic cond_ok(input instr_t x,
                                     input logic [2:0] f);
        case (x.f3)
            3'd0:    return f[0];
            3'd1:    return !f[0];
            3'd4:    return f[1];
            3'd5:    return !f[1];
            3'd6:    return f[2];
            3'd7:    return !f[2];
            default: return 1'b0;
        endcase
    endfunction

    function automatic logic [1:0] src(input logic [4:0] r);
        instr_t mi, wi;
        mi = q[q.size()-2];
        wi = q[q.size()-3];
        if (mi.rw && mi.rd != 0 && mi.rd == r) return 2'b10;
        if (wi.rw && wi.rd != 0 && wi.rd == r) return 2'b01;
        return 2'b00;
    endfunction

    function automatic logic m_hazard();
        instr_t ei;
        ei = q[q.size()-1];
        return ei.rs == 2'b01 && ei.rd != 0
            && (ei.rd == Rs1D || ei.rd == Rs2D);
    endfunction

    function automatic logic m_redirect();
        instr_t ei;
        ei = q[q.size()-1];
        return ei.jp || (ei.br && cond_ok(ei, FlagsE));
    endfunction

    task automatic check_all();
        instr_t ei, mi, wi;
        logic hz, rd;
        ei = q[q.size()-1];
        mi = q[q.size()-2];
        wi = q[q.size()-3];
        hz = m_hazard();
        rd = m_redirect();
        chk("PCSrcE", {7'd0, PCSrcE}, {7'd0, rd});
        chk("FlushD", {7'd0, FlushD}, {7'd0, rd});
        chk("StallFD", {7'd0, StallFD}, {7'd0, hz && !rd});
        chk("ForwardAE", {6'd0, ForwardAE}, {6'd0, src(ei.a)});
        chk("ForwardBE", {6'd0, ForwardBE}, {6'd0, src(ei.b)});
        chk("ALUSrcE", {7'd0, ALUSrcE}, {7'd0, ei.as});
        chk("ALUOpE", {6'd0, ALUOpE}, {6'd0, ei.op});
        chk("MemWriteM", {7'd0, MemWriteM}, {7'd0, mi.mw});
        chk("RegWriteW", {7'd0, RegWriteW}, {7'd0, wi.rw});
        chk("ResultSrcW", {6'd0, ResultSrcW}, {6'd0, wi.rs});
        chk("RdW", {3'd0, RdW}, {3'd0, wi.rd});
    endtask

    // inputs already set at negedge; check, then clock once
    task automatic cyc();
        instr_t di;
        logic kill;
        #1;
        if (armed) check_all();
        kill = m_hazard() || m_redirect();
        di = '{BranchD, JumpD, MemWriteD, ALUSrcD, RegWriteD,
               ResultSrcD, ALUOpD, funct3D, Rs1D, Rs2D, RdD};
        @(posedge clk);
        if (reset) begin
            repeat (3) q.push_back('0);
            armed = 1;
        end else begin
            q.push_back(kill ? instr_t'('0) : di);
        end
        while (q.size() > 4) void'(q.pop_front());
        @(negedge clk);
    endtask

    task automatic clr_d();
        BranchD = 0; JumpD = 0; MemWriteD = 0; ALUSrcD = 0;
        RegWriteD = 0; ResultSrcD = 0; ALUOpD = 0;
        funct3D = 0; Rs1D = 0; Rs2D = 0; RdD = 0;
        FlagsE = 0;
    endtask

    task automatic rand_d();
        BranchD    = ($urandom_range(0, 5) == 0);
        JumpD      = ($urandom_range(0, 9) == 0);
        MemWriteD  = 1'($urandom);
        ALUSrcD    = 1'($urandom);
        RegWriteD  = 1'($urandom);
        ResultSrcD = 2'($urandom_range(0, 2));
        ALUOpD     = 2'($urandom);
        funct3D    = 3'($urandom);
        Rs1D       = 5'($urandom_range(0, 7));
        Rs2D       = 5'($urandom_range(0, 7));
        RdD        = 5'($urandom_range(0, 7));
        FlagsE     = 3'($urandom);
    endtask

    initial begin
        repeat (3) q.push_back('0);
        clr_d();
        reset = 1;
        @(negedge clk);

        // reset holds everything at zero
        RegWriteD = 1; RdD = 3;
        cyc();
        cyc();
        chk("rst_RegWriteW", {7'd0, RegWriteW}, 8'd0);
        chk("rst_RdW", {3'd0, RdW}, 8'd0);
        reset = 0;
        cyc();
        clr_d();
        cyc();
        chk("lat2_RegWriteW", {7'd0, RegWriteW}, 8'd0);
        cyc();
        chk("lat3_RegWriteW", {7'd0, RegWriteW}, 8'd1);
        chk("lat3_RdW", {3'd0, RdW}, 8'd3);

        // load-use stall, bubble, then WB forward
        clr_d(); ResultSrcD = 2'b01; RegWriteD = 1; RdD = 5;
        cyc();
        clr_d(); Rs1D = 5; ALUSrcD = 1; ALUOpD = 2;
        RegWriteD = 1; RdD = 6;
        #1 chk("lu_StallFD", {7'd0, StallFD}, 8'd1);
        cyc();
        chk("lu_bubble_ALUSrcE", {7'd0, ALUSrcE}, 8'd0);
        chk("lu_bubble_ALUOpE", {6'd0, ALUOpE}, 8'd0);
        cyc();
        chk("lu_ForwardAE", {6'd0, ForwardAE}, 8'd1);
        chk("lu_ALUOpE", {6'd0, ALUOpE}, 8'd2);

        // MEM forward beats WB forward
        clr_d(); RegWriteD = 1; RdD = 7;
        cyc();
        cyc();
        clr_d(); Rs1D = 7; Rs2D = 7; RdD = 8;
        cyc();
        chk("pri_ForwardAE", {6'd0, ForwardAE}, 8'd2);
        chk("pri_ForwardBE", {6'd0, ForwardBE}, 8'd2);

        // x0 never stalls or forwards
        clr_d(); ResultSrcD = 2'b01; RegWriteD = 1; RdD = 0;
        cyc();
        clr_d(); Rs1D = 0;
        #1 chk("x0_StallFD", {7'd0, StallFD}, 8'd0);
        cyc();
        chk("x0_ForwardAE", {6'd0, ForwardAE}, 8'd0);

        // BNE taken, then not taken, then reserved funct3
        clr_d(); BranchD = 1; funct3D = 3'b001;
        cyc();
        clr_d(); ALUSrcD = 1; ALUOpD = 3; FlagsE = 3'b000;
        #1 chk("bne_PCSrcE", {7'd0, PCSrcE}, 8'd1);
        chk("bne_FlushD", {7'd0, FlushD}, 8'd1);
        cyc();
        chk("bne_flush_ALUSrcE", {7'd0, ALUSrcE}, 8'd0);
        chk("bne_flush_ALUOpE", {6'd0, ALUOpE}, 8'd0);
        clr_d(); BranchD = 1; funct3D = 3'b001;
        cyc();
        clr_d(); FlagsE = 3'b001;
        #1 chk("bne_nt_PCSrcE", {7'd0, PCSrcE}, 8'd0);
        cyc();
        clr_d(); BranchD = 1; funct3D = 3'b010;
        cyc();
        clr_d(); FlagsE = 3'b000;
        #1 chk("f3_010_PCSrcE", {7'd0, PCSrcE}, 8'd0);
        cyc();

        // jump in E while a load hazard is also present
        clr_d(); JumpD = 1; ResultSrcD = 2'b01;
        RegWriteD = 1; RdD = 9;
        cyc();
        clr_d(); Rs1D = 9;
        #1 chk("jl_PCSrcE", {7'd0, PCSrcE}, 8'd1);
        chk("jl_FlushD", {7'd0, FlushD}, 8'd1);
        chk("jl_StallFD", {7'd0, StallFD}, 8'd0);
        cyc();

        // random traffic with occasional mid-flight reset
        for (int i = 0; i < 400; i++) begin
            rand_d();
            reset = ($urandom_range(0, 39) == 0);
            cyc();
        end
        reset = 0;
        clr_d();
        cyc();

        $display("End of test - %0d assertions evaluated, %0d failures",
                 n_assert, n_fail);
        $finish;
    end

endmodule
